// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, start/stop framing at CLKS_PER_BIT.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       tx,
    output logic                       busy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W+1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT-1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W-1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS-1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] head;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;

    logic baud_done;
    logic stop_done;
    logic pop;
    logic push_ok;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    function automatic logic calc_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    assign head      = mem[rd_ptr];
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign stop_done = (state == STOP) && baud_done && (bit_cnt == STOP_LAST);
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);

    // A pop happens only when a frame starts, either from IDLE or chained off the last STOP cycle.
    always_comb begin
        pop = 1'b0;
        if (enable && !empty && ((state == IDLE) || stop_done)) begin
            pop = 1'b1;
        end
    end

    assign push_ok = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            if (wr_en && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Shift register holds the remaining data bits; tx is loaded one bit ahead of the shift.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= head;
        end else if ((state == DATA) && baud_done) begin
            shift <= shift >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (pop) begin
            parity_bit <= calc_parity(head);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity_bit;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= START;
                                tx    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a frame-timing model.
// Works with or without UART_TX_PARITY_EN defined.
module tb_uart_tx_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int CPB       = 4;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F  = (1 + DATA_W + P + STOP_BITS) * CPB;
    localparam int CW = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              tx;
    logic              busy;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mq[$];
    bit                m_in_frame;
    int                m_t;
    logic [DATA_W-1:0] m_word;
    bit                m_ovf;

    logic cap [1024];
    int   n;
    logic [15:0] pat;
    logic [DATA_W-1:0] dec;

    uart_tx_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_frame = 1'b0;
        m_t        = 0;
        m_word     = '0;
        m_ovf      = 1'b0;
    endtask

    // Frame-level model: a frame is F cycles long and the bit shown is chosen by offset / CPB.
    task automatic model_edge();
        bit pop;
        bit push_ok;
        if (rst) begin
            model_reset();
            return;
        end
        pop     = enable && (mq.size() > 0) && (!m_in_frame || m_t == F-1);
        push_ok = wr_en && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            m_word     = mq.pop_front();
            m_in_frame = 1'b1;
            m_t        = 0;
        end else if (m_in_frame) begin
            if (m_t == F-1) m_in_frame = 1'b0;
            else            m_t++;
        end
        if (push_ok)    mq.push_back(wr_data);
        else if (wr_en) m_ovf = 1'b1;
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_in_frame) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return m_word[b-1];
        if (P == 1 && b == DATA_W+1) return ^m_word;
        return 1'b1;
    endfunction

    task automatic check_all();
        check_val("tx",       32'(tx),       32'(exp_tx()));
        check_val("busy",     32'(busy),     32'(m_in_frame));
        check_val("count",    32'(count),    32'(mq.size()));
        check_val("full",     32'(full),     32'(mq.size() == DEPTH));
        check_val("empty",    32'(empty),    32'(mq.size() == 0));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Records tx while busy; stops once busy falls after having been high, or at the limit.
    task automatic measure(input int limit, output int cnt);
        cnt = 0;
        for (int i = 0; i < limit; i++) begin
            if (busy) begin
                cap[cnt] = tx;
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        step();
        step();
        check_val("rst_tx",       32'(tx),       32'd1);
        check_val("rst_busy",     32'(busy),     32'd0);
        check_val("rst_empty",    32'(empty),    32'd1);
        check_val("rst_count",    32'(count),    32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step();

        // single 0xAA frame
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        measure(F + 20, n);
        check_val("aa_len", 32'(n), 32'(F));
`ifdef UART_TX_PARITY_EN
        pat = {5'b0, 1'b1, 1'b0, 8'hAA, 1'b0};
`else
        pat = {6'b0, 1'b1, 8'hAA, 1'b0};
`endif
        for (int b = 0; b < F/CPB; b++) begin
            check_val("aa_bit", 32'(cap[b*CPB + CPB/2]), 32'(pat[b]));
        end
        check_val("aa_count", 32'(count), 32'd0);

        // two frames back to back
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_data = 8'h18;
        step();
        wr_en = 1'b0;
        measure(2*F + 20, n);
        check_val("b2b_len",   32'(n),        32'(2*F));
        check_val("b2b_stop",  32'(cap[F-1]), 32'd1);
        check_val("b2b_start", 32'(cap[F]),   32'd0);

        // fill with enable low, overflow on fifth push, then drain
        enable = 1'b0;
        wr_en  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = DATA_W'(8'h31 + k);
            step();
            if (k == 3) begin
                check_val("fill_full",  32'(full),  32'd1);
                check_val("fill_count", 32'(count), 32'd4);
            end
        end
        wr_en = 1'b0;
        check_val("ovf_set",   32'(overflow), 32'd1);
        check_val("ovf_count", 32'(count),    32'd4);
        enable = 1'b1;
        measure(4*F + 20, n);
        check_val("drain_len", 32'(n), 32'(4*F));
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < DATA_W; i++) begin
                dec[i] = cap[j*F + (1+i)*CPB + CPB/2];
            end
            check_val("drain_word", 32'(dec), 32'(8'h31 + j));
        end
        check_val("ovf_sticky", 32'(overflow), 32'd1);

        // enable dropped mid-frame with one word still queued
        wr_en   = 1'b1;
        wr_data = DATA_W'($urandom);
        step();
        wr_data = DATA_W'($urandom);
        step();
        wr_en = 1'b0;
        repeat (4*CPB) step();
        enable = 1'b0;
        measure(F + 20, n);
        repeat (F) step();
        check_val("hold_tx",    32'(tx),    32'd1);
        check_val("hold_busy",  32'(busy),  32'd0);
        check_val("hold_count", 32'(count), 32'd1);

        // asynchronous reset during DATA
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        repeat (3*CPB) step();
        rst = 1'b1;
        #1;
        check_val("arst_tx",    32'(tx),    32'd1);
        check_val("arst_busy",  32'(busy),  32'd0);
        check_val("arst_count", 32'(count), 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        step();

`ifdef UART_TX_PARITY_EN
        wr_en   = 1'b1;
        wr_data = 8'h07;
        step();
        wr_en = 1'b0;
        measure(F + 20, n);
        check_val("par07_len", 32'(n), 32'd44);
        check_val("par07_bit", 32'(cap[9*CPB + CPB/2]), 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        measure(F + 20, n);
        check_val("parAA_bit", 32'(cap[9*CPB + CPB/2]), 32'd0);
`endif

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            enable  = ((c / 300) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = DATA_W'($urandom);
            step();
        end
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: the successor to the single-byte transmitter. Words are pushed into an internal FIFO and serialised on `tx` LSB-first with start/stop framing at a programmable bit period. Frames go out back-to-back while the FIFO holds data and `enable` is high. It sits between the host-side write logic and the serial pin, and replaces the unbuffered byte-at-a-time transmitter.

## Interface
- `DATA_W`, 8: data bits per frame (5..9).
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit (≥2).
- `STOP_BITS`, 1: number of stop bits (1 or 2).

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  permits a new frame to start; it does not abort a frame in flight.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  DATA_W  word to transmit.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is in progress (START..STOP).
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `count`  out  $clog2(DEPTH+1)  words currently stored.
- `overflow`  out  1  sticky; set when a push is dropped; cleared only by `rst`.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0. FSM=IDLE, pointers=0, baud counter=0. Reset mid-frame truncates the frame immediately and `tx` returns to 1.
- FIFO: circular buffer with a write pointer and a read pointer, each wrapping at DEPTH. A push is accepted if `!full`, or if a pop occurs in the same cycle. Otherwise the word is dropped and `overflow` is set. A simultaneous push and pop leaves `count` unchanged.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE→START when `enable && !empty`. The head word is popped into the shift register in that same cycle.
- Each non-IDLE state holds for CLKS_PER_BIT cycles. The baud counter loads 0 on state entry and counts to CLKS_PER_BIT-1.
- START: `tx`=0.
- DATA: `tx`=shift[0]. The register shifts right each bit. A bit counter advances 0..DATA_W-1, then the FSM moves to PARITY or STOP.
- STOP: `tx`=1 for STOP_BITS bit periods.
- At the last cycle of STOP: if `enable && !empty`, pop the next word and go directly to START (no idle gap). Otherwise go to IDLE.
- Deasserting `enable` mid-frame: the current frame completes; no new frame starts.
- `busy`=1 in every state except IDLE.

## Timing
- `tx` is registered. The start bit appears on `tx` the cycle after IDLE sees `enable && !empty`.
- Frame length F = (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames have period exactly F, with no gap cycles.
- `count`, `full` and `empty` update the cycle after a push or pop.
- A word pushed into an empty FIFO while IDLE with `enable`=1 produces its start bit 2 cycles after the `wr_en` edge.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. `tx` carries even parity (XOR of the DATA_W data bits) for one bit period. F includes P=1.
- Undefined: no PARITY state and no parity logic; DATA is followed directly by STOP.

## Test plan
- Reset, then push 0xAA with `enable`=1 (DATA_W=8, CLKS_PER_BIT=4, no parity). Required: `tx` = 0, 0,1,0,1,0,1,0,1, 1, each bit held 4 cycles; frame is 40 cycles; `busy` falls after it; `count` returns to 0.
- Push 0xAA and 0x18 in consecutive cycles. Required: the second start bit immediately follows the first stop bit; 80 cycles in total; `busy` high throughout.
- With `enable`=0, push 5 words with DEPTH=4. Required: `full`=1 and `count`=4 after the 4th push; 5th word dropped; `overflow`=1 and stays 1. Then set `enable`=1: exactly 4 frames go out, in order.
- Drop `enable` in the middle of the DATA bits of frame 1 while 1 word is still queued. Required: frame 1 completes; `tx` stays 1 afterwards; `count`=1.
- Assert `rst` during the DATA state. Required: `tx`=1, `busy`=0, `count`=0 asynchronously, before the next clock edge.
- With `UART_TX_PARITY_EN`, send 0x07. Required: parity bit 1 and a 44-cycle frame. Then send 0xAA: parity bit 0.
